// File: rtl/uart_word_sender_if.sv
// Producer-side handshake for uart_word_sender: one WIDTH-bit word offered with valid/ready.
interface uart_word_sender_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] word_in;
   logic             word_valid;
   logic             word_ready;

   modport master (output word_in, output word_valid, input word_ready);
   modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/uart_word_sender.sv
// Splits an accepted WIDTH-bit word into bytes and feeds them one at a time to a UART
// transmitter, pacing on tx_ready and flagging a transmitter that never goes busy.
module uart_word_sender #(
   parameter int WIDTH        = 32,
   parameter bit MSB_FIRST    = 1'b1,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                clk,
   input  logic                rst,
   uart_word_sender_if.slave   word,
   output logic                done,
   output logic                tx_err,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_ready
);
   localparam int NBYTES = (WIDTH + 7) / 8;
   localparam int SREG_W = NBYTES * 8;
   localparam int CNT_W  = $clog2(NBYTES) + 1;
   localparam int TMR_W  = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE} state_t;

   state_t            state;
   state_t            state_next;
   logic [SREG_W-1:0] sreg;
   logic [CNT_W-1:0]  cnt;
   logic [TMR_W-1:0]  timer;
   logic              accept;
   logic              last_byte;
   logic              timeout;

   assign accept    = word.word_valid && word.word_ready;
   assign last_byte = (cnt == CNT_W'(NBYTES - 1));
   assign timeout   = (timer == TMR_W'(BUSY_TIMEOUT - 1));
   assign tx_data   = MSB_FIRST ? sreg[SREG_W-1 -: 8] : sreg[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The outgoing byte is always the edge byte of sreg, so shifting is what advances tx_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg   <= '0;
         cnt    <= '0;
         timer  <= '0;
         tx_err <= 1'b0;
      end else begin
         if (accept) begin
            sreg   <= SREG_W'(word.word_in);
            cnt    <= '0;
            tx_err <= 1'b0;
         end else if (state == WAIT_IDLE && tx_ready && !last_byte) begin
            sreg <= MSB_FIRST ? (sreg << 8) : (sreg >> 8);
            cnt  <= cnt + CNT_W'(1);
         end
         if (state == SEND) begin
            timer <= '0;
         end else if (state == WAIT_BUSY && tx_ready) begin
            timer <= timer + TMR_W'(1);
            if (timeout) begin
               tx_err <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (accept) state_next = SEND;
         SEND:      if (tx_ready) state_next = WAIT_BUSY;
         WAIT_BUSY: if (!tx_ready || timeout) state_next = WAIT_IDLE;
         WAIT_IDLE: begin
            if (tx_ready) begin
               if (!last_byte) state_next = SEND;
               else            state_next = accept ? SEND : IDLE;
            end
         end
         default:   state_next = IDLE;
      endcase
   end

   // The final WAIT_IDLE cycle already counts as idle, so the next word can be taken alongside done.
   always_comb begin
      word.word_ready = 1'b0;
      done            = 1'b0;
      tx_start        = 1'b0;
      case (state)
         IDLE:      word.word_ready = 1'b1;
         SEND:      tx_start = tx_ready;
         WAIT_IDLE: begin
            if (tx_ready && last_byte) begin
               done            = 1'b1;
               word.word_ready = 1'b1;
            end
         end
         default:   ;
      endcase
      if (rst) begin
         tx_start = 1'b0;
         done     = 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_word_sender.sv
// Directed and randomized bench for uart_word_sender against a simple UART model and a
// byte-order reference computed from the word with shifts.
module tb_uart_word_sender;
   localparam int FRAME        = 20;
   localparam int BUSY_TIMEOUT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       done, tx_err, tx_start;
   logic [7:0] tx_data;
   logic       tx_ready = 1'b1;
   logic       done_l, err_l, start_l;
   logic [7:0] data_l;
   logic       done_m, err_m, start_m;
   logic [7:0] data_m;

   uart_word_sender_if #(.WIDTH(32)) wif ();
   uart_word_sender_if #(.WIDTH(12)) wif_l ();
   uart_word_sender_if #(.WIDTH(12)) wif_m ();

   uart_word_sender #(.WIDTH(32), .MSB_FIRST(1'b1), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .word(wif.slave), .done(done), .tx_err(tx_err),
      .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready));

   uart_word_sender #(.WIDTH(12), .MSB_FIRST(1'b0), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut_lsb (
      .clk(clk), .rst(rst), .word(wif_l.slave), .done(done_l), .tx_err(err_l),
      .tx_start(start_l), .tx_data(data_l), .tx_ready(1'b1));

   uart_word_sender #(.WIDTH(12), .MSB_FIRST(1'b1), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut_msb (
      .clk(clk), .rst(rst), .word(wif_m.slave), .done(done_m), .tx_err(err_m),
      .tx_start(start_m), .tx_data(data_m), .tx_ready(1'b1));

   always #5 clk = ~clk;

   bit         stuck = 1'b0;
   bit         hold = 1'b0;
   bit         data_watch = 1'b0;
   int         busy_cnt = 0;
   logic       start_seen = 1'b0;
   logic       prev_start = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int         viol = 0;
   int         done_cnt = 0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_err = 0;
   logic [7:0] cap_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] q_l[$];
   logic [7:0] q_m[$];

   // UART model: goes busy on the edge after a start pulse and stays busy for FRAME cycles.
   always @(posedge clk) begin
      if (stuck) begin
         tx_ready <= 1'b1;
      end else if (hold) begin
         tx_ready <= 1'b0;
      end else if (start_seen) begin
         tx_ready <= 1'b0;
         busy_cnt <= FRAME;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         tx_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      start_seen = tx_start;
      if (tx_start) begin
         cap_q.push_back(tx_data);
         if (!tx_ready) viol++;
         if (prev_start) viol++;
      end
      if (data_watch && busy_cnt > 0 && tx_data !== prev_data) viol++;
      prev_data  = tx_data;
      prev_start = tx_start;
      if (done) done_cnt++;
      if (start_l) q_l.push_back(data_l);
      if (start_m) q_m.push_back(data_m);
   end

   task automatic tick();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_err++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] ref_byte(input logic [31:0] w, input int nbytes, input bit msb_first, input int idx);
      int k;
      k = msb_first ? (nbytes - 1 - idx) : idx;
      return 8'((w >> (8 * k)) & 32'hFF);
   endfunction

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) exp_q.push_back(ref_byte(w, 4, 1'b1, i));
   endtask

   task automatic apply_stimulus(input logic [31:0] w);
      wif.word_in    = w;
      wif.word_valid = 1'b1;
      tick();
      wif.word_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check_output(tag, 32'(done), 1);
   endtask

   task automatic compare_bytes(input string tag);
      logic [7:0] obs;
      check_output({tag, "_count"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
         check_output($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(exp_q[i]));
      end
   endtask

   initial begin
      logic [31:0] w, w2;
      logic [11:0] w12;
      int n, bad, starts, last_start;

      wif.word_in = '0;   wif.word_valid = 1'b0;
      wif_l.word_in = '0; wif_l.word_valid = 1'b0;
      wif_m.word_in = '0; wif_m.word_valid = 1'b0;
      tick();
      tick();
      check_output("reset_word_ready", 32'(wif.word_ready), 1);
      check_output("reset_done", 32'(done), 0);
      check_output("reset_tx_err", 32'(tx_err), 0);
      check_output("reset_tx_start", 32'(tx_start), 0);
      check_output("reset_tx_data", 32'(tx_data), 0);
      rst = 1'b0;
      data_watch = 1'b1;
      tick();

      // Single word: first start the cycle after accept, one done, bytes MSB first.
      cap_q.delete(); exp_q.delete();
      w = 32'hA5C30F81;
      push_word(w);
      wif.word_in = w; wif.word_valid = 1'b1;
      tick();
      check_output("s1_latency", 32'(tx_start), 1);
      wif.word_valid = 1'b0;
      n = done_cnt;
      wait_done("s1_done", 400);
      tick(); tick();
      check_output("s1_done_once", done_cnt - n, 1);
      check_output("s1_tx_err", 32'(tx_err), 0);
      compare_bytes("s1");

      // word_valid held throughout: second word taken exactly in the done cycle.
      cap_q.delete(); exp_q.delete();
      w = 32'hA5C30F81; w2 = 32'h12345678;
      push_word(w); push_word(w2);
      wif.word_in = w; wif.word_valid = 1'b1;
      tick();
      wif.word_in = w2;
      bad = 0; n = 0;
      while (done !== 1'b1 && n < 400) begin
         if (wif.word_ready) bad++;
         tick();
         n++;
      end
      check_output("s2_ready_while_busy", bad, 0);
      check_output("s2_done", 32'(done), 1);
      check_output("s2_ready_at_done", 32'(wif.word_ready), 1);
      tick();
      check_output("s2_accept_at_done", 32'(tx_start), 1);
      wif.word_valid = 1'b0;
      wait_done("s2_done2", 400);
      compare_bytes("s2");

      // Transmitter busy at accept: no start until tx_ready returns.
      hold = 1'b1;
      tick(); tick();
      cap_q.delete(); exp_q.delete();
      w = $urandom;
      push_word(w);
      apply_stimulus(w);
      bad = 0;
      repeat (50) begin
         if (tx_start) bad++;
         tick();
      end
      check_output("s3_no_start_while_busy", bad, 0);
      hold = 1'b0;
      tick();
      check_output("s3_start_after_ready", 32'(tx_start), 1);
      wait_done("s3_done", 400);
      compare_bytes("s3");

      // Transmitter never goes busy: timeout per byte, all bytes still sent.
      stuck = 1'b1;
      tick();
      cap_q.delete(); exp_q.delete();
      w = $urandom;
      push_word(w);
      apply_stimulus(w);
      starts = 0; last_start = 0; bad = 0; n = 0;
      while (done !== 1'b1 && n < 200) begin
         if (tx_start) begin
            starts++;
            if (starts == 1) check_output("s4_err_before_timeout", 32'(tx_err), 0);
            else if (cyc - last_start != BUSY_TIMEOUT + 2) bad++;
            last_start = cyc;
         end
         tick();
         n++;
      end
      check_output("s4_done", 32'(done), 1);
      check_output("s4_starts", starts, 4);
      check_output("s4_gap", bad, 0);
      check_output("s4_tx_err", 32'(tx_err), 1);
      stuck = 1'b0;
      tick(); tick();
      w2 = $urandom;
      push_word(w2);
      apply_stimulus(w2);
      check_output("s4_err_cleared", 32'(tx_err), 0);
      wait_done("s4_done2", 400);
      compare_bytes("s4");

      // Reset during the second byte aborts the word; next word restarts at byte 0.
      cap_q.delete(); exp_q.delete();
      w = $urandom;
      apply_stimulus(w);
      starts = 0; n = 0;
      while (n < 400) begin
         if (tx_start) starts++;
         if (starts == 2) break;
         tick();
         n++;
      end
      check_output("s5_second_byte", starts, 2);
      tick(); tick(); tick();
      data_watch = 1'b0;
      rst = 1'b1;
      tick();
      check_output("s5_ready_after_rst", 32'(wif.word_ready), 1);
      check_output("s5_start_after_rst", 32'(tx_start), 0);
      check_output("s5_data_after_rst", 32'(tx_data), 0);
      rst = 1'b0;
      n = done_cnt; bad = 0;
      repeat (60) begin
         if (tx_start) bad++;
         tick();
      end
      check_output("s5_no_start", bad, 0);
      check_output("s5_no_done", done_cnt - n, 0);
      exp_q.push_back(ref_byte(w, 4, 1'b1, 0));
      exp_q.push_back(ref_byte(w, 4, 1'b1, 1));
      w2 = $urandom;
      push_word(w2);
      apply_stimulus(w2);
      wait_done("s5_done", 400);
      compare_bytes("s5");
      tick();
      data_watch = 1'b1;

      // Random back-to-back words with word_valid kept high.
      cap_q.delete(); exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         w = $urandom;
         push_word(w);
         wif.word_in = w; wif.word_valid = 1'b1;
         n = 0;
         while (wif.word_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
         end
         check_output("rnd_ready", 32'(wif.word_ready), 1);
         tick();
      end
      wif.word_valid = 1'b0;
      wait_done("rnd_done", 400);
      compare_bytes("rnd");

      // 12-bit words: two bytes, order per MSB_FIRST.
      q_l.delete(); q_m.delete();
      wif_l.word_in = 12'hABC; wif_m.word_in = 12'hABC;
      wif_l.word_valid = 1'b1; wif_m.word_valid = 1'b1;
      tick();
      wif_l.word_valid = 1'b0; wif_m.word_valid = 1'b0;
      repeat (30) tick();
      check_output("w12_lsb_count", q_l.size(), 2);
      check_output("w12_lsb_b0", 32'(q_l[0]), 32'hBC);
      check_output("w12_lsb_b1", 32'(q_l[1]), 32'h0A);
      check_output("w12_msb_b0", 32'(q_m[0]), 32'h0A);
      check_output("w12_msb_b1", 32'(q_m[1]), 32'hBC);
      check_output("w12_err_tied_ready", 32'(err_l), 1);
      q_l.delete(); q_m.delete();
      w12 = 12'($urandom);
      wif_l.word_in = w12; wif_m.word_in = w12;
      wif_l.word_valid = 1'b1; wif_m.word_valid = 1'b1;
      tick();
      wif_l.word_valid = 1'b0; wif_m.word_valid = 1'b0;
      repeat (30) tick();
      for (int i = 0; i < 2; i++) begin
         check_output($sformatf("w12r_lsb_b%0d", i), 32'(q_l[i]), 32'(ref_byte(32'(w12), 2, 1'b0, i)));
         check_output($sformatf("w12r_msb_b%0d", i), 32'(q_m[i]), 32'(ref_byte(32'(w12), 2, 1'b1, i)));
      end
      check_output("w12_msb_done_seen", 32'(done_m | err_m), 32'(err_m));

      check_output("protocol_violations", viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
